ekg_sample_conditioner: RTL and testbench
=========================================

Name: ekg_sample_conditioner

Overview:
- Upstream neighbour of the scrolling graph renderer. Takes raw unsigned ADC samples of the EKG front end and removes the DC baseline.
- Box-car decimates the signal, scales it and saturates it into the signed OUT_WIDTH format the graph stores per column.
- Emits one data_valid_out pulse per display column. The graph's write counter advances on that pulse, so each pulse is one column.

Parameters:
- ADC_WIDTH, 12, width of unsigned raw sample.
- OUT_WIDTH, 8, width of signed output sample; equals the graph's DATA_RESOLUTION.
- DECIM_LOG2, 2, decimation factor is 2^DECIM_LOG2 accepted samples per output.
- BASELINE_SHIFT, 6, EMA time constant for baseline, alpha = 2^-BASELINE_SHIFT.
- GAIN_SHIFT, 2, arithmetic right shift applied after averaging.
- SETTLE_SAMPLES, 256, samples consumed in SETTLE before output starts.

Ports:
- clk_in  input  1  HDMI/pixel domain clock; the only clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- sample_valid_in  input  1  one-cycle strobe; sample_in is accepted on that edge.
- sample_in  input  ADC_WIDTH  unsigned raw ADC code.
- freeze_in  input  1  high: suppress data_valid_out; processing continues.
- data_valid_out  output  1  one-cycle pulse, new column sample.
- data_out  output  OUT_WIDTH  signed conditioned sample; held between pulses.
- saturated_out  output  1  pulses with data_valid_out when clipping occurred.
- state_out  output  2  INIT=0, SETTLE=1, RUN=2; 3 is never produced.

Behaviour:
- Reset: asynchronous assert, synchronous-safe release. On reset every register clears:
  - state=INIT; baseline B=0; accumulator, decimation counter and settle counter=0.
  - data_out=0, data_valid_out=0, saturated_out=0.
  - Reset mid-group discards the partial accumulation; no output is emitted.
- B is unsigned, ADC_WIDTH+BASELINE_SHIFT bits, and stores baseline<<BASELINE_SHIFT. Integer baseline b = B>>BASELINE_SHIFT.
- INIT:
  - First accepted sample x sets B <= x<<BASELINE_SHIFT and moves to SETTLE.
  - Nothing is accumulated and there is no output.
- SETTLE:
  - Each accepted sample updates B <= B + x - b.
  - Settle counter increments. When the SETTLE_SAMPLES-th sample is accepted, go to RUN and clear the accumulator and decimation counter.
  - No output.
- RUN, per accepted sample:
  - d = x - b, signed ADC_WIDTH+1 bits, using b from before this sample's update. B is updated as in SETTLE.
  - d is summed into acc, signed ADC_WIDTH+1+DECIM_LOG2 bits, so it cannot overflow.
  - On the 2^DECIM_LOG2-th sample of a group:
    - a = (acc incl. this d) >>> DECIM_LOG2, then s = a >>> GAIN_SHIFT. Both shifts are arithmetic (floor).
    - Clamp s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. saturated_out=1 iff the clamp changed s.
    - acc restarts at 0 for the next group.
  - Groups are aligned to RUN entry.
- Pipeline and output timing:
  - Edge k accepts the last sample of a group. Edge k+1 registers the group result. Edge k+2 drives data_out/saturated_out and raises data_valid_out for exactly one cycle.
  - Latency is 2 cycles, independent of sample spacing.
  - Back-to-back sample_valid_in every cycle is supported with no loss. Arbitrary gaps are allowed.
- freeze_in is sampled at edge k+2:
  - If high, data_valid_out stays 0, and data_out and saturated_out keep their old values.
  - The group is consumed anyway and baseline tracking continues.
- sample_valid_in while in INIT with freeze_in high behaves the same; freeze only gates output.
- data_out changes only on an emitted pulse.

Test Plan:
- Constant 2048 input:
  - state_out reads 1 after the first sample and 2 after 256 more samples.
  - After that, one data_valid_out every 4 samples with data_out=0 and saturated_out=0.
- Step to 2248 at a group boundary, baseline 2048, default params:
  - d = 200, 197, 194, 191; sum 782; a=195; data_out=48.
  - Pulse lands exactly 2 cycles after the 4th sample edge.
- Saturation:
  - x=4095 group (d≈2047) -> data_out=127, saturated_out=1.
  - x=0 group (d≈-2048) -> data_out=-128, saturated_out=1.
- Timing equivalence:
  - The same sample sequence delivered every cycle and with random 0–20 cycle gaps gives identical data_out values and pulse count.
- freeze_in high across 3 groups:
  - No pulses and data_out held.
  - After release, the next group output matches a reference model whose baseline tracked through the frozen samples.
- rst_n_in pulsed low for 1 cycle asynchronously, mid-group in RUN:
  - All outputs are 0 immediately, state_out=0, and no stray pulse appears.
  - Re-entry needs a first sample plus 256 settle samples.

Source files
------------

// File: rtl/ekg_sample_conditioner.sv
// rtl/ekg_sample_conditioner.sv - EKG baseline removal, box-car decimation, gain and saturation
// Produces one signed column sample per 2^DECIM_LOG2 accepted ADC samples.
module ekg_sample_conditioner #(
    parameter int ADC_WIDTH      = 12,
    parameter int OUT_WIDTH      = 8,
    parameter int DECIM_LOG2     = 2,
    parameter int BASELINE_SHIFT = 6,
    parameter int GAIN_SHIFT     = 2,
    parameter int SETTLE_SAMPLES = 256
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 sample_valid_in,
    input  logic [ADC_WIDTH-1:0] sample_in,
    input  logic                 freeze_in,
    output logic                 data_valid_out,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 saturated_out,
    output logic [1:0]           state_out
);

    localparam int BW  = ADC_WIDTH + BASELINE_SHIFT;
    localparam int DW  = ADC_WIDTH + 1;
    localparam int AW  = DW + DECIM_LOG2;
    localparam int SCW = $clog2(SETTLE_SAMPLES + 1);
    localparam int DCW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                state;
    logic [BW-1:0]         base_q;
    logic [SCW-1:0]        settle_cnt;
    logic [DCW-1:0]        decim_cnt;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  sum_q;
    logic                  sum_valid;
    logic [OUT_WIDTH-1:0]  res_q;
    logic                  res_sat_q;
    logic                  res_valid;

    logic [ADC_WIDTH-1:0]  base_int;
    logic [BW-1:0]         base_next;
    logic signed [DW-1:0]  diff;
    logic signed [AW-1:0]  acc_next;
    logic                  group_last;
    logic                  settle_last;
    logic signed [AW-1:0]  avg;
    logic signed [AW-1:0]  scaled;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [OUT_WIDTH-1:0]  clamped;

    // B holds baseline<<BASELINE_SHIFT, so B + x - b is the EMA step with alpha = 2^-BASELINE_SHIFT
    assign base_int    = base_q[BW-1:BASELINE_SHIFT];
    assign base_next   = base_q + {{BASELINE_SHIFT{1'b0}}, sample_in}
                                - {{BASELINE_SHIFT{1'b0}}, base_int};
    assign diff        = $signed({1'b0, sample_in}) - $signed({1'b0, base_int});
    assign acc_next    = acc_q + AW'(diff);
    assign group_last  = (decim_cnt == DCW'((2 ** DECIM_LOG2) - 1));
    assign settle_last = (settle_cnt == SCW'(SETTLE_SAMPLES - 1));

    assign avg    = sum_q >>> DECIM_LOG2;
    assign scaled = avg >>> GAIN_SHIFT;

    // Out of range when the bits above the output sign bit are not all copies of the sign
    assign sat_hi  = ~scaled[AW-1] & (|scaled[AW-2:OUT_WIDTH-1]);
    assign sat_lo  =  scaled[AW-1] & ~(&scaled[AW-2:OUT_WIDTH-1]);
    assign clamped = sat_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                     sat_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                              scaled[OUT_WIDTH-1:0];

    assign state_out = state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_INIT;
            base_q     <= '0;
            settle_cnt <= '0;
            decim_cnt  <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            sum_valid  <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (sample_valid_in) begin
                case (state)
                    ST_INIT: begin
                        base_q     <= {sample_in, {BASELINE_SHIFT{1'b0}}};
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        base_q <= base_next;
                        if (settle_last) begin
                            settle_cnt <= '0;
                            acc_q      <= '0;
                            decim_cnt  <= '0;
                            state      <= ST_RUN;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        base_q <= base_next;
                        if (group_last) begin
                            sum_q     <= acc_next;
                            sum_valid <= 1'b1;
                            acc_q     <= '0;
                            decim_cnt <= '0;
                        end else begin
                            acc_q     <= acc_next;
                            decim_cnt <= decim_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

    // Result stage then output stage; freeze only gates the final register update
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_q          <= '0;
            res_sat_q      <= 1'b0;
            res_valid      <= 1'b0;
            data_valid_out <= 1'b0;
            data_out       <= '0;
            saturated_out  <= 1'b0;
        end else begin
            res_valid <= sum_valid;
            if (sum_valid) begin
                res_q     <= clamped;
                res_sat_q <= sat_hi | sat_lo;
            end
            data_valid_out <= res_valid & ~freeze_in;
            if (res_valid && !freeze_in) begin
                data_out      <= res_q;
                saturated_out <= res_sat_q;
            end
        end
    end

endmodule

// File: tb/tb_ekg_sample_conditioner.sv
// tb/tb_ekg_sample_conditioner.sv - directed self-checking bench for ekg_sample_conditioner
module tb_ekg_sample_conditioner;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        sample_valid_in = 1'b0;
    logic [11:0] sample_in = '0;
    logic        freeze_in = 1'b0;
    logic        data_valid_out;
    logic [7:0]  data_out;
    logic        saturated_out;
    logic [1:0]  state_out;

    ekg_sample_conditioner #(
        .ADC_WIDTH(12), .OUT_WIDTH(8), .DECIM_LOG2(2),
        .BASELINE_SHIFT(6), .GAIN_SHIFT(2), .SETTLE_SAMPLES(256)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .sample_valid_in(sample_valid_in),
        .sample_in(sample_in),
        .freeze_in(freeze_in),
        .data_valid_out(data_valid_out),
        .data_out(data_out),
        .saturated_out(saturated_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_edge = 0;

    logic signed [7:0] pd[$];
    logic              psat[$];
    int                pc[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (data_valid_out === 1'b1) begin
            pd.push_back(data_out);
            psat.push_back(saturated_out);
            pc.push_back(cyc);
        end
    end

    // Reference model of the conditioning arithmetic
    int m_state, m_b, m_scnt, m_acc, m_dcnt;
    int exp_q[$];
    bit exp_sat[$];

    task automatic model_reset();
        m_state = 0; m_b = 0; m_scnt = 0; m_acc = 0; m_dcnt = 0;
    endtask

    task automatic model_accept(input int x);
        int d, a, s;
        bit sat;
        if (m_state == 0) begin
            m_b = x << 6;
            m_state = 1;
            m_scnt = 0;
        end else if (m_state == 1) begin
            m_b = m_b + x - (m_b >> 6);
            m_scnt++;
            if (m_scnt == 256) begin
                m_state = 2; m_acc = 0; m_dcnt = 0;
            end
        end else begin
            d = x - (m_b >> 6);
            m_b = m_b + x - (m_b >> 6);
            m_acc += d;
            m_dcnt++;
            if (m_dcnt == 4) begin
                a = m_acc >>> 2;
                s = a >>> 2;
                sat = 0;
                if (s > 127) begin s = 127; sat = 1; end
                if (s < -128) begin s = -128; sat = 1; end
                exp_q.push_back(s);
                exp_sat.push_back(sat);
                m_acc = 0; m_dcnt = 0;
            end
        end
    endtask

    task automatic send(input int x);
        sample_in = 12'(x);
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        last_edge = cyc;
        model_accept(x);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic clear_logs();
        pd.delete(); psat.delete(); pc.delete();
        exp_q.delete(); exp_sat.delete();
    endtask

    task automatic settle_const();
        rst_n_in = 1'b0;
        model_reset();
        #10;
        rst_n_in = 1'b1;
        clear_logs();
        repeat (257) send(2048);
    endtask

    task automatic test_reset();
        model_reset();
        checks++;
        if (state_out !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data: got %0d expected 0", data_out); end
        checks++;
        if (data_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", data_valid_out); end
        checks++;
        if (saturated_out !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b expected 0", saturated_out); end
        rst_n_in = 1'b1;
        gap(1);
    endtask

    task automatic test_settle_constant();
        clear_logs();
        send(2048);
        checks++;
        if (state_out !== 2'd1) begin failures++; $display("FAIL settle_enter: got %0d expected 1", state_out); end
        repeat (255) send(2048);
        checks++;
        if (state_out !== 2'd1) begin failures++; $display("FAIL settle_255: got %0d expected 1", state_out); end
        send(2048);
        checks++;
        if (state_out !== 2'd2) begin failures++; $display("FAIL settle_run: got %0d expected 2", state_out); end
        checks++;
        if (pd.size() != 0) begin failures++; $display("FAIL settle_no_pulse: got %0d pulses expected 0", pd.size()); end
        repeat (12) send(2048);
        gap(3);
        checks++;
        if (pd.size() != 3) begin failures++; $display("FAIL const_pulses: got %0d expected 3", pd.size()); end
        for (int i = 0; i < pd.size(); i++) begin
            checks++;
            if (pd[i] !== 8'sh00 || psat[i] !== 1'b0) begin
                failures++;
                $display("FAIL const_value[%0d]: got %0d sat %b expected 0 sat 0", i, pd[i], psat[i]);
            end
        end
    endtask

    task automatic test_step();
        int k;
        clear_logs();
        repeat (4) send(2248);
        k = last_edge;
        gap(4);
        checks++;
        if (pd.size() != 1) begin failures++; $display("FAIL step_pulses: got %0d expected 1", pd.size()); end
        if (pd.size() >= 1) begin
            checks++;
            if (pd[0] !== 8'sh30) begin failures++; $display("FAIL step_value: got %0d expected 48", pd[0]); end
            checks++;
            if (psat[0] !== 1'b0) begin failures++; $display("FAIL step_sat: got %b expected 0", psat[0]); end
            checks++;
            if (pc[0] != k + 2) begin failures++; $display("FAIL step_latency: got cycle %0d expected %0d", pc[0], k + 2); end
        end
    endtask

    task automatic test_saturation();
        settle_const();
        repeat (4) send(4095);
        gap(4);
        checks++;
        if (pd.size() != 1 || pd[0] !== 8'sh7f || psat[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_high: got n=%0d value %0d sat %b expected n=1 127 sat 1",
                     pd.size(), (pd.size() > 0) ? pd[0] : 8'sh0, (psat.size() > 0) ? psat[0] : 1'b0);
        end
        settle_const();
        repeat (4) send(0);
        gap(4);
        checks++;
        if (pd.size() != 1 || pd[0] !== 8'sh80 || psat[0] !== 1'b1) begin
            failures++;
            $display("FAIL sat_low: got n=%0d value %0d sat %b expected n=1 -128 sat 1",
                     pd.size(), (pd.size() > 0) ? pd[0] : 8'sh0, (psat.size() > 0) ? psat[0] : 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int seq[16] = '{2100, 2300, 1900, 2500, 3000, 3100, 2900, 3050,
                        1500, 1400, 1600, 1550, 2048, 2000, 2100, 2050};
        logic signed [7:0] r1[$];
        settle_const();
        for (int i = 0; i < 16; i++) send(seq[i]);
        gap(4);
        checks++;
        if (pd.size() != 4) begin failures++; $display("FAIL b2b_pulses: got %0d expected 4", pd.size()); end
        for (int i = 0; i < pd.size() && i < exp_q.size(); i++) begin
            checks++;
            if (pd[i] !== exp_q[i] || psat[i] !== exp_sat[i]) begin
                failures++;
                $display("FAIL b2b_value[%0d]: got %0d sat %b expected %0d sat %b", i, pd[i], psat[i], exp_q[i], exp_sat[i]);
            end
        end
        r1 = pd;
        settle_const();
        for (int i = 0; i < 16; i++) begin
            send(seq[i]);
            gap($urandom_range(0, 20));
        end
        gap(4);
        checks++;
        if (pd.size() != r1.size()) begin failures++; $display("FAIL gap_pulses: got %0d expected %0d", pd.size(), r1.size()); end
        for (int i = 0; i < pd.size() && i < r1.size(); i++) begin
            checks++;
            if (pd[i] !== r1[i]) begin failures++; $display("FAIL gap_value[%0d]: got %0d expected %0d", i, pd[i], r1[i]); end
        end
    endtask

    task automatic test_freeze();
        logic [7:0] held;
        logic       held_sat;
        int         n0;
        clear_logs();
        repeat (4) send(2300);
        gap(4);
        checks++;
        if (pd.size() != 1) begin failures++; $display("FAIL pre_freeze_pulses: got %0d expected 1", pd.size()); end
        held = data_out;
        held_sat = saturated_out;
        n0 = pd.size();
        freeze_in = 1'b1;
        repeat (4) send(2600);
        repeat (4) send(2700);
        repeat (4) send(2500);
        gap(4);
        freeze_in = 1'b0;
        checks++;
        if (pd.size() != n0) begin failures++; $display("FAIL freeze_pulses: got %0d expected %0d", pd.size(), n0); end
        checks++;
        if (data_out !== held || saturated_out !== held_sat) begin
            failures++;
            $display("FAIL freeze_hold: got %0d sat %b expected %0d sat %b", data_out, saturated_out, held, held_sat);
        end
        repeat (4) send(2100);
        gap(4);
        checks++;
        if (pd.size() != n0 + 1) begin
            failures++;
            $display("FAIL unfreeze_pulses: got %0d expected %0d", pd.size(), n0 + 1);
        end else if (pd[n0] !== exp_q[exp_q.size()-1] || psat[n0] !== exp_sat[exp_sat.size()-1]) begin
            failures++;
            $display("FAIL unfreeze_value: got %0d sat %b expected %0d sat %b",
                     pd[n0], psat[n0], exp_q[exp_q.size()-1], exp_sat[exp_sat.size()-1]);
        end
    endtask

    task automatic test_async_reset();
        int n0;
        send(2300);
        send(2300);
        n0 = pd.size();
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        checks++;
        if (state_out !== 2'd0) begin failures++; $display("FAIL areset_state: got %0d expected 0", state_out); end
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL areset_data: got %0d expected 0", data_out); end
        checks++;
        if (data_valid_out !== 1'b0 || saturated_out !== 1'b0) begin
            failures++;
            $display("FAIL areset_flags: got valid %b sat %b expected 0 0", data_valid_out, saturated_out);
        end
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        send(2300);
        send(2300);
        checks++;
        if (state_out !== 2'd1) begin failures++; $display("FAIL areset_reinit: got %0d expected 1", state_out); end
        repeat (254) send(2048);
        checks++;
        if (state_out !== 2'd1) begin failures++; $display("FAIL areset_settle: got %0d expected 1", state_out); end
        send(2048);
        checks++;
        if (state_out !== 2'd2) begin failures++; $display("FAIL areset_run: got %0d expected 2", state_out); end
        gap(4);
        checks++;
        if (pd.size() != n0) begin failures++; $display("FAIL areset_stray: got %0d pulses expected %0d", pd.size(), n0); end
    endtask

    initial begin
        #12;
        test_reset();
        test_settle_constant();
        test_step();
        test_saturation();
        test_back_to_back();
        test_freeze();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
